mc_core: RTL

Parametrised multi-cycle CPU core: the next generation of the single-cycle 16-bit core. It fetches 16-bit instructions and executes them over a small state machine on a single unified memory bus with a req/ack handshake, so memories may insert wait states. Datapath width and address width are configurable. The core sits between the top-level testbench/SoC wrapper and a shared RAM/ROM bus.

---
 rtl/mc_core_pkg.sv | 51 +++++
 rtl/mc_regfile.sv | 46 ++++
 rtl/mc_core.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mc_core_pkg.sv
// ============================================================================
// mc_core_pkg : opcodes, FSM state encodings and instruction field positions
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mc_core_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_MEM   = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_LSL = 4'h6;
  localparam logic [3:0] OP_LSR = 4'h7;
  localparam logic [3:0] OP_ADI = 4'h8;
  localparam logic [3:0] OP_LDI = 4'h9;
  localparam logic [3:0] OP_LDW = 4'hA;
  localparam logic [3:0] OP_STW = 4'hB;
  localparam logic [3:0] OP_BRZ = 4'hC;
  localparam logic [3:0] OP_JAL = 4'hD;
  localparam logic [3:0] OP_ILL = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS_HI  = 7;
  localparam int RS_LO  = 4;
  localparam int RT_HI  = 3;
  localparam int RT_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Opcodes whose second operand is rd rather than rt.
  function automatic logic reads_rd(input logic [3:0] op);
    return (op == OP_ADI) || (op == OP_BRZ) || (op == OP_STW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_regfile.sv
// ============================================================================
// mc_regfile : 16 x DW register file, two async read ports, one sync write
//              port, r0 hardwired to zero
// Revision   : 1.0
// ============================================================================
`default_nettype none

module mc_regfile #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [3:0]    raddr_b,
  output logic [DW-1:0] rdata_b,
  input  logic          we,
  input  logic [3:0]    waddr,
  input  logic [DW-1:0] wdata
);

  logic [DW-1:0] regs_q [16];
  logic [DW-1:0] regs_d [16];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

`default_nettype wire

// File: rtl/mc_core.sv
// ============================================================================
// mc_core  : multi-cycle 16-bit-ISA CPU core on a req/ack unified memory bus
//            Optional illegal-opcode trap enabled by `MC_CORE_TRAP_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module mc_core #(
  parameter int            DW       = 16,
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [AW-1:0] TRAP_VEC = 16'h0004
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          retire,
  output logic          halted,
  output logic          trap,
  output logic [AW-1:0] dbg_pc,
  output logic [1:0]    dbg_state
);

  import mc_core_pkg::*;

  localparam int SHW = $clog2(DW);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic          halted_q, halted_d;

  logic [3:0]    op, rd, rs, rt;
  logic [7:0]    imm8;
  logic [DW-1:0] src_a, src_b, alu_res;
  logic [DW-1:0] sext_imm, zext_imm, link_val;
  logic [AW-1:0] pc_plus2, br_off;
  logic          rf_we;
  logic [DW-1:0] rf_wdata;

  assign op   = ir_q[OP_HI:OP_LO];
  assign rd   = ir_q[RD_HI:RD_LO];
  assign rs   = ir_q[RS_HI:RS_LO];
  assign rt   = ir_q[RT_HI:RT_LO];
  assign imm8 = ir_q[IMM_HI:IMM_LO];

  mc_regfile #(.DW(DW)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rs),
    .rdata_a (src_a),
    .raddr_b (reads_rd(op) ? rd : rt),
    .rdata_b (src_b),
    .we      (rf_we),
    .waddr   (rd),
    .wdata   (rf_wdata)
  );

  assign sext_imm = DW'($signed(imm8));
  assign zext_imm = DW'(imm8);
  assign pc_plus2 = pc_q + AW'(2);
  assign br_off   = AW'($signed({imm8, 1'b0}));

  always_comb begin
    link_val           = '0;
    link_val[AW-1:0]   = pc_plus2;
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_NOT:  alu_res = ~src_a;
      OP_LSL:  alu_res = src_a << src_b[SHW-1:0];
      OP_LSR:  alu_res = src_a >> src_b[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    rf_we    = 1'b0;
    rf_wdata = '0;
    retire   = 1'b0;
    trap     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata[15:0];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_plus2;
        retire  = 1'b1;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LSL, OP_LSR: begin
            rf_we    = 1'b1;
            rf_wdata = alu_res;
          end
          OP_ADI: begin
            rf_we    = 1'b1;
            rf_wdata = src_b + sext_imm;
          end
          OP_LDI: begin
            rf_we    = 1'b1;
            rf_wdata = zext_imm;
          end
          OP_LDW, OP_STW: begin
            state_d = ST_MEM;
            pc_d    = pc_q;
            retire  = 1'b0;
          end
          OP_BRZ: begin
            if (src_b == '0) begin
              pc_d = pc_plus2 + br_off;
            end
          end
          OP_JAL: begin
            rf_we    = 1'b1;
            rf_wdata = link_val;
            pc_d     = src_a[AW-1:0];
          end
          OP_HLT: begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
            pc_d     = pc_q;
          end
          OP_ILL: begin
`ifdef MC_CORE_TRAP_EN
            trap   = 1'b1;
            retire = 1'b0;
            pc_d   = TRAP_VEC;
`endif
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        if (mem_ack) begin
          if (op == OP_LDW) begin
            rf_we    = 1'b1;
            rf_wdata = mem_rdata;
          end
          pc_d    = pc_plus2;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

`ifndef MC_CORE_TRAP_EN
  logic unused_trap_vec;
  assign unused_trap_vec = ^TRAP_VEC;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  // Gating with rst drops an in-flight request the moment reset asserts.
  assign mem_req   = ~rst & ((state_q == ST_FETCH) | (state_q == ST_MEM));
  assign mem_we    = (state_q == ST_MEM) && (op == OP_STW);
  assign mem_addr  = (state_q == ST_MEM) ? src_a[AW-1:0] : pc_q;
  assign mem_wdata = (state_q == ST_MEM) ? src_b : '0;

  assign halted    = halted_q;
  assign dbg_pc    = pc_q;
  assign dbg_state = state_q;

endmodule

`default_nettype wire
